// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icache_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        FILL = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam int OFFSET_W   = 4;   // 16 lines
    localparam int TAG_W      = 4;
    localparam int OFFSET_LSB = 2;   // byte address bits [1:0] are ignored
    localparam int TAG_LSB    = OFFSET_LSB + OFFSET_W;
    localparam int INSTR_W    = 32;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Bundles the fetch, cache and memory signals of the refill controller.
// Latency: n/a (wiring only).
// Backpressure: fetch held until valid/err; memory side uses req/gnt then rvalid.
interface icache_refill_ctrl_if #(
    parameter int ADDR_W = 10
);
    import icache_pkg::*;

    // fetch stage side
    logic                  fetch_req;
    logic [ADDR_W-1:0]     fetch_addr;
    logic                  fetch_kill;
    logic                  fetch_valid;
    logic [INSTR_W-1:0]    fetch_instr;
    logic                  fetch_err;
    // cache array side
    logic [OFFSET_W-1:0]   cache_offset;
    logic [TAG_W-1:0]      cache_tag;
    logic                  cache_we_n;
    logic                  cache_en;
    logic [INSTR_W-1:0]    cache_wdata;
    logic                  cache_match;
    logic [INSTR_W-1:0]    cache_data;
    // instruction memory side
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [INSTR_W-1:0]    mem_rdata;

    // controller view
    modport master (
        input  fetch_req, fetch_addr, fetch_kill,
        output fetch_valid, fetch_instr, fetch_err,
        output cache_offset, cache_tag, cache_we_n, cache_en, cache_wdata,
        input  cache_match, cache_data,
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    // environment view (fetch stage, cache array, memory)
    modport slave (
        output fetch_req, fetch_addr, fetch_kill,
        input  fetch_valid, fetch_instr, fetch_err,
        input  cache_offset, cache_tag, cache_we_n, cache_en, cache_wdata,
        output cache_match, cache_data,
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/icache_refill_ctrl_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
// Latency: count visible one cycle after the increment strobe.
// Backpressure: none; increments while saturated are dropped.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // count up on strobe, hold once every bit is set
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Fetch-side lookup and single-word refill controller for a 16-line direct-mapped icache.
// Latency: hit 0 cycles; miss returns 3 cycles after the rvalid cycle's predecessor (T0 -> T4 best case).
// Backpressure: fetch held until valid/err; REQ waits for gnt, WAIT aborts after TIMEOUT cycles.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    icache_refill_ctrl_if.master  bus,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [INSTR_W-1:0]  r_rdata_q;
    logic                r_kill_q;
    logic [TMR_W-1:0]    r_timer;

    logic w_lookup;
    logic w_hit;
    logic w_miss;
    logic w_timeout;

    // a redirect in IDLE wins over the request: no lookup, nothing counted
    assign w_lookup  = (r_state == IDLE) && bus.fetch_req && !bus.fetch_kill;
    assign w_hit     = w_lookup && bus.cache_match;
    assign w_miss    = w_lookup && !bus.cache_match;
    // rvalid in the final WAIT cycle still completes the refill
    assign w_timeout = (r_state == WAIT) && !bus.mem_rvalid &&
                       (r_timer == TMR_W'(TIMEOUT - 1));

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_miss) w_next = REQ;
            REQ: begin
                if (bus.mem_gnt)         w_next = WAIT;
                else if (bus.fetch_kill) w_next = IDLE;
            end
            WAIT: begin
                if (bus.mem_rvalid)      w_next = FILL;
                else if (w_timeout)      w_next = IDLE;
            end
            FILL:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // miss address, refill data, wait timer and deferred-kill flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr_q  <= '0;
            r_rdata_q <= '0;
            r_kill_q  <= 1'b0;
            r_timer   <= '0;
        end else begin
            if (w_miss) begin
                r_addr_q <= bus.fetch_addr;
            end
            if ((r_state == REQ) && bus.mem_gnt) begin
                r_timer <= '0;
            end else if (r_state == WAIT) begin
                r_timer <= r_timer + TMR_W'(1);
            end
            if ((r_state == WAIT) && bus.mem_rvalid) begin
                r_rdata_q <= bus.mem_rdata;
            end
            // once granted the read must drain, so a redirect is only remembered
            if ((r_state == RESP) || w_timeout) begin
                r_kill_q <= 1'b0;
            end else if (bus.fetch_kill &&
                         ((r_state == WAIT) || (r_state == FILL) ||
                          ((r_state == REQ) && bus.mem_gnt))) begin
                r_kill_q <= 1'b1;
            end
        end
    end

    // output decode; the lookup path is fully combinational from fetch_addr
    always_comb begin
        bus.fetch_valid  = 1'b0;
        bus.fetch_instr  = '0;
        bus.fetch_err    = 1'b0;
        bus.cache_we_n   = 1'b1;
        bus.cache_en     = 1'b0;
        bus.cache_wdata  = '0;
        bus.mem_req      = 1'b0;
        bus.mem_addr     = {r_addr_q[ADDR_W-1:OFFSET_LSB], 2'b00};
        bus.cache_offset = r_addr_q[OFFSET_LSB +: OFFSET_W];
        bus.cache_tag    = r_addr_q[TAG_LSB +: TAG_W];
        case (r_state)
            IDLE: begin
                bus.cache_offset = bus.fetch_addr[OFFSET_LSB +: OFFSET_W];
                bus.cache_tag    = bus.fetch_addr[TAG_LSB +: TAG_W];
                bus.cache_en     = w_lookup;
                if (w_hit) begin
                    bus.fetch_valid = 1'b1;
                    bus.fetch_instr = bus.cache_data;
                end
            end
            REQ: bus.mem_req = 1'b1;
            // a redirect already taken (or arriving now) means nobody wants the error
            WAIT: bus.fetch_err = w_timeout && !r_kill_q && !bus.fetch_kill;
            FILL: begin
                bus.cache_en    = 1'b1;
                bus.cache_we_n  = 1'b0;
                bus.cache_wdata = r_rdata_q;
            end
            RESP: begin
                bus.fetch_valid = !r_kill_q && !bus.fetch_kill;
                bus.fetch_instr = r_rdata_q;
            end
            default: ;
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .i_inc (w_hit),
        .o_cnt (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .i_inc (w_miss),
        .o_cnt (miss_cnt)
    );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: acts as fetch stage, cache array and memory.
// Expected results come from a transaction-level cache/counter model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_icache_refill_ctrl;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic CLK;
    logic RST;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    icache_refill_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    icache_refill_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- environment cache array ----------------
    logic        man_mode;
    logic        man_match;
    logic [31:0] man_data;
    logic        env_rst;
    logic [15:0] env_vld;
    logic [3:0]  env_tag  [16];
    logic [31:0] env_data [16];

    always_comb begin
        if (man_mode) begin
            bus.cache_match = man_match;
            bus.cache_data  = man_data;
        end else begin
            bus.cache_match = env_vld[bus.cache_offset] && (env_tag[bus.cache_offset] == bus.cache_tag);
            bus.cache_data  = env_data[bus.cache_offset];
        end
    end

    always @(posedge CLK or posedge env_rst) begin
        if (env_rst) begin
            env_vld <= '0;
        end else if (bus.cache_en && !bus.cache_we_n) begin
            env_vld[bus.cache_offset]  <= 1'b1;
            env_tag[bus.cache_offset]  <= bus.cache_tag;
            env_data[bus.cache_offset] <= bus.cache_wdata;
        end
    end

    // ---------------- reference model ----------------
    bit   [15:0] m_vld;
    logic [3:0]  m_tag  [16];
    logic [31:0] m_data [16];
    int          m_hits;
    int          m_misses;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // ---------------- checking ----------------
    int n_tests;
    int n_fail;
    int both_high;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // observations from one fetch transaction
    int          o_lat, o_valid_cnt, o_err_cnt, o_err_cyc, o_fill_cnt, o_req_cycles;
    logic [31:0] o_instr, o_fill_wdata;
    logic [3:0]  o_fill_off, o_fill_tag;
    logic [9:0]  o_mem_addr;
    logic        o_addr_ok;

    task automatic drive_idle();
        bus.fetch_req  = 1'b0;
        bus.fetch_kill = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic observe(input int c);
        if (bus.fetch_valid) begin
            o_valid_cnt++;
            if (o_lat < 0) begin
                o_lat   = c;
                o_instr = bus.fetch_instr;
            end
        end
        if (bus.fetch_err) begin
            o_err_cnt++;
            if (o_err_cyc < 0) o_err_cyc = c;
        end
        if (bus.fetch_valid && bus.fetch_err) both_high++;
        if (bus.mem_req) begin
            if (o_req_cycles == 0) o_mem_addr = bus.mem_addr;
            else if (bus.mem_addr != o_mem_addr) o_addr_ok = 1'b0;
            o_req_cycles++;
        end
        if (bus.cache_en && !bus.cache_we_n) begin
            o_fill_cnt++;
            o_fill_wdata = bus.cache_wdata;
            o_fill_off   = bus.cache_offset;
            o_fill_tag   = bus.cache_tag;
        end
    endtask

    // Presents one fetch (cycle 0 = first request cycle). Memory grants after g
    // request cycles and returns rd r cycles after the grant (r=0: never).
    // kill_c >= 1 pulses fetch_kill in that cycle and drops the request afterwards.
    task automatic do_fetch(input logic [9:0] addr, input int g, input int r,
                            input logic [31:0] rd, input int kill_c, input int max_c);
        int req_cnt, cg;
        bit done;
        o_lat = -1; o_valid_cnt = 0; o_err_cnt = 0; o_err_cyc = -1; o_fill_cnt = 0;
        o_req_cycles = 0; o_instr = '0; o_fill_wdata = '0; o_fill_off = '0; o_fill_tag = '0;
        o_mem_addr = '0; o_addr_ok = 1'b1;
        req_cnt = 0; cg = -1; done = 1'b0;
        for (int c = 0; c < max_c; c++) begin
            bus.fetch_addr = addr;
            if (kill_c >= 0 && c > kill_c) begin
                bus.fetch_req  = 1'b0;
                bus.fetch_kill = 1'b0;
            end else begin
                bus.fetch_req  = 1'b1;
                bus.fetch_kill = (c == kill_c);
            end
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            if (bus.mem_req) begin
                if (req_cnt == g) begin
                    bus.mem_gnt = 1'b1;
                    cg = c;
                end
                req_cnt++;
            end
            if (cg >= 0 && r > 0 && c == cg + r) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rd;
            end
            @(negedge CLK);
            observe(c);
            done = (kill_c < 0) && (bus.fetch_valid || bus.fetch_err);
            @(posedge CLK); #1;
            if (done) break;
        end
        for (int k = 0; k < 2; k++) begin
            drive_idle();
            @(negedge CLK);
            observe(max_c + k);
            @(posedge CLK); #1;
        end
        drive_idle();
    endtask

    // Model-predicted fetch, executed and compared.
    task automatic run(input string nm, input logic [9:0] addr, input int g, input int r,
                       input logic [31:0] rd, input int kill_c, input int max_c);
        logic [3:0] off, tg;
        int e_lat, e_err, e_err_cyc, e_fill, e_req, gnt_c, resp_c;
        bit e_valid;
        logic [31:0] e_instr;
        off = addr[5:2];
        tg  = addr[9:6];
        e_lat = -1; e_err = 0; e_err_cyc = -1; e_fill = 0; e_req = 0; e_valid = 1'b0; e_instr = '0;
        if (m_vld[off] && m_tag[off] == tg) begin
            e_valid = 1'b1;
            e_lat   = 0;
            e_instr = m_data[off];
            m_hits  = sat(m_hits);
        end else begin
            m_misses = sat(m_misses);
            gnt_c    = 1 + g;
            e_req    = g + 1;
            if (kill_c >= 1 && kill_c < gnt_c) begin
                e_req = kill_c;
            end else if (r == 0) begin
                e_err     = (kill_c < 0) ? 1 : 0;
                e_err_cyc = gnt_c + TIMEOUT;
            end else begin
                resp_c  = gnt_c + r + 2;
                e_fill  = 1;
                e_valid = !(kill_c >= 1 && kill_c <= resp_c);
                if (e_valid) begin
                    e_lat   = resp_c;
                    e_instr = rd;
                end
            end
        end
        do_fetch(addr, g, r, rd, kill_c, max_c);
        chk($sformatf("%s_lat", nm),      o_lat, e_lat);
        chk($sformatf("%s_nvalid", nm),   o_valid_cnt, e_valid ? 1 : 0);
        chk($sformatf("%s_nerr", nm),     o_err_cnt, e_err);
        chk($sformatf("%s_nfill", nm),    o_fill_cnt, e_fill);
        chk($sformatf("%s_reqcyc", nm),   o_req_cycles, e_req);
        if (e_valid) chk($sformatf("%s_instr", nm), o_instr, e_instr);
        if (e_err > 0) chk($sformatf("%s_errcyc", nm), o_err_cyc, e_err_cyc);
        if (e_fill > 0) begin
            chk($sformatf("%s_wdata", nm),  o_fill_wdata, rd);
            chk($sformatf("%s_woff", nm),   o_fill_off, off);
            chk($sformatf("%s_wtag", nm),   o_fill_tag, tg);
            m_vld[off]  = 1'b1;
            m_tag[off]  = tg;
            m_data[off] = rd;
        end
        if (e_req > 0) begin
            chk($sformatf("%s_maddr", nm),  o_mem_addr, {addr[9:2], 2'b00});
            chk($sformatf("%s_mstable", nm), o_addr_ok, 1);
        end
        chk($sformatf("%s_hitcnt", nm),  hit_cnt, m_hits);
        chk($sformatf("%s_misscnt", nm), miss_cnt, m_misses);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_valid"}, bus.fetch_valid, 0);
        chk({nm, "_err"},   bus.fetch_err, 0);
        chk({nm, "_mreq"},  bus.mem_req, 0);
        chk({nm, "_wen"},   bus.cache_we_n, 1);
        chk({nm, "_cen"},   bus.cache_en, 0);
        chk({nm, "_instr"}, bus.fetch_instr, 0);
        chk({nm, "_maddr"}, bus.mem_addr, 0);
        chk({nm, "_hit"},   hit_cnt, 0);
        chk({nm, "_miss"},  miss_cnt, 0);
    endtask

    // single-cycle lookup vectors with the cache array driven by hand
    typedef struct {
        logic [9:0]  addr;
        logic        match;
        logic [31:0] data;
        logic        kill;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [3:0]  exp_off;
        logic [3:0]  exp_tag;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{10'h044, 1'b1, 32'h0000_0013, 1'b0, 1'b1, 32'h0000_0013, 4'h1, 4'h1};
        tbl[1] = '{10'h3FC, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 4'hF, 4'hF};
        tbl[2] = '{10'h087, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'hA5A5_A5A5, 4'h1, 4'h2};
        tbl[3] = '{10'h200, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 4'h8};
        tbl[4] = '{10'h2A8, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0000, 4'hA, 4'hA};

        n_tests = 0; n_fail = 0; both_high = 0;
        m_vld = '0; m_hits = 0; m_misses = 0;
        RST = 1'b1; env_rst = 1'b1;
        man_mode = 1'b1; man_match = 1'b0; man_data = '0;
        bus.fetch_addr = '0; bus.mem_rdata = '0;
        drive_idle();

        // reset values
        #22;
        chk_reset_outputs("rst");
        @(negedge CLK);
        RST = 1'b0; env_rst = 1'b0;
        @(posedge CLK); #1;

        // first miss through an empty cache
        man_mode = 1'b0;
        run("miss040", 10'h040, 0, 1, 32'hDEAD_BEEF, -1, 20);

        // hand-driven lookups
        man_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            man_match      = tbl[i].match;
            man_data       = tbl[i].data;
            bus.fetch_addr = tbl[i].addr;
            bus.fetch_kill = tbl[i].kill;
            bus.fetch_req  = 1'b1;
            @(negedge CLK);
            chk($sformatf("tbl%0d_valid", i), bus.fetch_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_instr", i), bus.fetch_instr, tbl[i].exp_instr);
            chk($sformatf("tbl%0d_off", i),   bus.cache_offset, tbl[i].exp_off);
            chk($sformatf("tbl%0d_tag", i),   bus.cache_tag, tbl[i].exp_tag);
            chk($sformatf("tbl%0d_mreq", i),  bus.mem_req, 0);
            if (tbl[i].match && !tbl[i].kill) m_hits = sat(m_hits);
            @(posedge CLK); #1;
            drive_idle();
        end
        @(negedge CLK);
        chk("tbl_hitcnt",  hit_cnt, m_hits);
        chk("tbl_misscnt", miss_cnt, m_misses);
        chk("tbl_nomreq",  bus.mem_req, 0);
        @(posedge CLK); #1;

        // multi-cycle corner cases through the environment cache
        man_mode = 1'b0;
        run("gntdly",    10'h180, 5, 1, $urandom, -1, 30);
        run("timeout",   10'h2C0, 0, 0, 32'h0,    -1, 100);
        run("after_tmo", 10'h2C0, 0, 2, $urandom, -1, 20);
        run("kill_req",  10'h300, 100, 1, 32'h0,   2, 10);
        run("kill_wait", 10'h344, 0, 3, 32'h1234_5678, 3, 12);
        run("rehit",     10'h344, 0, 1, $urandom, -1, 20);

        // randomized traffic over a few conflicting lines
        for (int i = 0; i < 40; i++) begin
            logic [9:0] a;
            a = {2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3)), 2'($urandom)};
            run($sformatf("rnd%0d", i), a, $urandom_range(0, 3), $urandom_range(1, 3), $urandom, -1, 20);
        end

        // stray gnt/rvalid while idle
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
        @(negedge CLK);
        chk("ign_mreq0", bus.mem_req, 0);
        @(posedge CLK); #1;
        drive_idle();
        @(negedge CLK);
        chk("ign_mreq1",  bus.mem_req, 0);
        chk("ign_valid",  bus.fetch_valid, 0);
        chk("ign_wen",    bus.cache_we_n, 1);
        @(posedge CLK); #1;

        // hit counter saturation
        man_mode = 1'b1; man_match = 1'b1; man_data = 32'h0000_0013;
        bus.fetch_addr = 10'h044; bus.fetch_req = 1'b1;
        repeat ((1 << CNT_W) + 3) @(posedge CLK);
        #1;
        bus.fetch_req = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) m_hits = sat(m_hits);
        @(negedge CLK);
        chk("sat_hit",     hit_cnt, m_hits);
        chk("sat_hit_max", hit_cnt, 32'hFFFF);
        chk("sat_miss",    miss_cnt, m_misses);
        @(posedge CLK); #1;

        // asynchronous reset in the middle of WAIT
        man_match = 1'b0;
        bus.fetch_addr = 10'h1C4; bus.fetch_req = 1'b1;
        @(posedge CLK); #1;
        chk("rw_reqstate", bus.mem_req, 1);
        bus.mem_gnt = 1'b1;
        @(posedge CLK); #1;
        drive_idle();
        @(negedge CLK);
        chk("rw_waitreq", bus.mem_req, 0);
        chk("rw_maddr",   bus.mem_addr, 10'h1C4);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_outputs("rw");
        @(negedge CLK);
        RST = 1'b0;
        m_hits = 0; m_misses = 0;
        @(posedge CLK); #1;

        // normal operation resumes after reset
        man_mode = 1'b0;
        run("post_rst_a", 10'h1C4, 0, 1, $urandom, -1, 20);
        run("post_rst_b", 10'h1C4, 0, 1, $urandom, -1, 20);

        chk("never_valid_and_err", both_high, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
